// File: rtl/pipelined_control.sv
// pipelined_control: single-stage instruction decoder with a registered
// control word, a memory-op hold state and a flush state.
// Optional feature: define CTRL_ILLEGAL_TRAP_EN to trap opcodes 14/15
// (illegal pulse plus entry to FLUSH); otherwise they decode as a NOP.
module pipelined_control #(
   parameter int INSTR_W = 9,
   parameter int OPC_W   = 4,
   parameter int ALUOP_W = 4,
   parameter int MEM_LAT = 2
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [INSTR_W-1:0] instruction,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               stall,
   input  logic               flush,
   output logic               out_valid,
   output logic               branchFlag,
   output logic               memToRegFlag,
   output logic               memWriteFlag,
   output logic               regWriteFlag,
   output logic               putFlag,
   output logic               immtoRegFlag,
   output logic [ALUOP_W-1:0] ALUOp,
   output logic               illegal
);

   typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} state_t;

   typedef struct packed {
      logic               branch;
      logic               mem_to_reg;
      logic               mem_write;
      logic               reg_write;
      logic               put;
      logic               imm_to_reg;
      logic [ALUOP_W-1:0] aluop;
   } ctrl_t;

   // A single-cycle memory op never enters MEM_WAIT, so its write strobe
   // goes out together with the rest of the control word.
   localparam bit MEM_SINGLE = (MEM_LAT == 1);
   localparam logic [3:0] MEM_LOAD = 4'(MEM_LAT - 1);

   state_t             state;
   logic [3:0]         count;
   logic               pend_wr;
   ctrl_t              ctrl_q;
   ctrl_t              dec;
   logic [OPC_W-1:0]   opc;
   int unsigned        op;
   logic               is_mem;
   logic               unused_hi;

   assign opc       = instruction[OPC_W:1];
   assign op        = 32'(opc);
   assign is_mem    = (op == 1) || (op == 2);
   // Bits above the opcode field carry operands and do not affect decode.
   assign unused_hi = ^instruction[INSTR_W-1:OPC_W+1];

`ifdef CTRL_ILLEGAL_TRAP_EN
   logic illegal_q;
   logic is_trap;
   assign is_trap = (op == 14) || (op == 15);
   assign illegal = illegal_q;
`else
   assign illegal = 1'b0;
`endif

   // Accept only in RUN, never while held downstream or in reset.
   assign in_ready = reset_n && (state == RUN) && !stall;

   // Opcode decode table; undefined opcodes fall through to an all-zero word.
   always_comb begin
      // NOTE: every field gets a default before the case so that no path
      // leaves a bit unassigned and infers a latch.
      dec = '0;
      case (op)
         0:  begin dec.aluop = ALUOP_W'(4'b0111); dec.imm_to_reg = 1'b1; dec.reg_write = 1'b1; end
         1:  begin dec.aluop = ALUOP_W'(4'b0111); dec.mem_to_reg = 1'b1; dec.reg_write = 1'b1; end
         2:  begin dec.aluop = ALUOP_W'(4'b0111); dec.mem_write  = 1'b1; end
         3:  begin dec.aluop = ALUOP_W'(4'b0101); dec.reg_write  = 1'b1; end
         4:  begin dec.aluop = ALUOP_W'(4'b0110); dec.reg_write  = 1'b1; end
         5:  begin dec.aluop = ALUOP_W'(4'b0001); dec.reg_write  = 1'b1; end
         6:  begin dec.aluop = ALUOP_W'(4'b0010); dec.reg_write  = 1'b1; end
         7:  begin dec.aluop = ALUOP_W'(4'b0000); dec.reg_write  = 1'b1; end
         8:  begin dec.aluop = ALUOP_W'(4'b0111); dec.branch     = 1'b1; end
         9:  begin dec.aluop = ALUOP_W'(4'b1010); dec.branch     = 1'b1; end
         10: begin dec.aluop = ALUOP_W'(4'b1000); dec.branch     = 1'b1; end
         11: begin dec.aluop = ALUOP_W'(4'b1001); dec.branch     = 1'b1; end
         12: begin dec.aluop = ALUOP_W'(4'b0011); dec.reg_write  = 1'b1; dec.put = instruction[0]; end
         13: begin dec.aluop = ALUOP_W'(4'b0100); dec.reg_write  = 1'b1; dec.put = instruction[0]; end
         default: dec = '0;
      endcase
   end

   // Control FSM with registered control word: flush beats stall beats transfer.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: only a handful of control flops here, so every one is reset;
      // sequential state uses non-blocking assignments throughout.
      if (!reset_n) begin
         state     <= RUN;
         count     <= '0;
         pend_wr   <= 1'b0;
         out_valid <= 1'b0;
         ctrl_q    <= '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
         illegal_q <= 1'b0;
`endif
      end else if (flush) begin
         state     <= FLUSH;
         count     <= '0;
         pend_wr   <= 1'b0;
         out_valid <= 1'b0;
         ctrl_q    <= '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
         illegal_q <= 1'b0;
`endif
      end else if (stall) begin
         // Outputs and counter freeze; a pending flush still completes.
         if (state == FLUSH) state <= RUN;
      end else begin
         case (state)
            RUN: begin
               if (in_valid) begin
                  out_valid        <= 1'b1;
                  ctrl_q           <= dec;
                  ctrl_q.mem_write <= dec.mem_write && MEM_SINGLE;
                  if (is_mem && !MEM_SINGLE) begin
                     state   <= MEM_WAIT;
                     count   <= MEM_LOAD;
                     pend_wr <= dec.mem_write;
                  end
`ifdef CTRL_ILLEGAL_TRAP_EN
                  illegal_q <= is_trap;
                  if (is_trap) begin
                     ctrl_q <= '0;
                     state  <= FLUSH;
                  end
`endif
               end else begin
                  out_valid <= 1'b0;
                  ctrl_q    <= '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
                  illegal_q <= 1'b0;
`endif
               end
            end
            MEM_WAIT: begin
               // Control word holds; the write strobe fires on the last cycle.
               if (count == 4'd1) begin
                  count            <= '0;
                  state            <= RUN;
                  ctrl_q.mem_write <= pend_wr;
                  pend_wr          <= 1'b0;
               end else begin
                  count <= count - 4'd1;
               end
            end
            FLUSH: begin
               state     <= RUN;
               out_valid <= 1'b0;
               ctrl_q    <= '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
               illegal_q <= 1'b0;
`endif
            end
            default: state <= RUN;
         endcase
      end
   end

   assign branchFlag   = ctrl_q.branch;
   assign memToRegFlag = ctrl_q.mem_to_reg;
   assign memWriteFlag = ctrl_q.mem_write;
   assign regWriteFlag = ctrl_q.reg_write;
   assign putFlag      = ctrl_q.put;
   assign immtoRegFlag = ctrl_q.imm_to_reg;
   assign ALUOp        = ctrl_q.aluop;

endmodule

// File: tb/tb_pipelined_control.sv
// tb_pipelined_control: directed scenarios followed by randomized stimulus,
// all compared against a cycle-level behavioural model of the decoder.
module tb_pipelined_control;

   localparam int INSTR_W = 9;
   localparam int OPC_W   = 4;
   localparam int ALUOP_W = 4;
   localparam int MEM_LAT = 2;

   logic               clk = 1'b0;
   logic               reset_n;
   logic [INSTR_W-1:0] instruction;
   logic               in_valid;
   logic               in_ready;
   logic               stall;
   logic               flush;
   logic               out_valid;
   logic               branchFlag, memToRegFlag, memWriteFlag;
   logic               regWriteFlag, putFlag, immtoRegFlag;
   logic [ALUOP_W-1:0] ALUOp;
   logic               illegal;

   int checks = 0;
   int errors = 0;

   // Reference tables indexed by opcode. Flag order:
   // {branch, memToReg, memWrite, regWrite, put, immtoReg}
   logic [3:0] alu_tbl [16];
   logic [5:0] flag_tbl[16];

   // Model state: expected outputs plus how many more cycles the block is busy.
   logic       e_valid, e_illegal;
   logic [5:0] e_flags;
   logic [3:0] e_alu;
   int         busy;
   bit         flushing;
   bit         store_pending;

   pipelined_control #(
      .INSTR_W(INSTR_W), .OPC_W(OPC_W), .ALUOP_W(ALUOP_W), .MEM_LAT(MEM_LAT)
   ) dut (
      .clk(clk), .reset_n(reset_n), .instruction(instruction),
      .in_valid(in_valid), .in_ready(in_ready), .stall(stall), .flush(flush),
      .out_valid(out_valid), .branchFlag(branchFlag), .memToRegFlag(memToRegFlag),
      .memWriteFlag(memWriteFlag), .regWriteFlag(regWriteFlag), .putFlag(putFlag),
      .immtoRegFlag(immtoRegFlag), .ALUOp(ALUOp), .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] dut_word();
      return {20'd0, out_valid, illegal, branchFlag, memToRegFlag, memWriteFlag,
              regWriteFlag, putFlag, immtoRegFlag, ALUOp};
   endfunction

   function automatic logic [31:0] model_word();
      return {20'd0, e_valid, e_illegal, e_flags, e_alu};
   endfunction

   function automatic logic model_ready();
      return reset_n && busy == 0 && !flushing && !stall;
   endfunction

   task automatic model_clear();
      e_valid = 0; e_illegal = 0; e_flags = '0; e_alu = '0;
   endtask

   task automatic model_reset();
      model_clear();
      busy = 0; flushing = 0; store_pending = 0;
   endtask

   // Advance the model by one rising edge using the inputs presented to it.
   task automatic model_step();
      int opn;
      opn = (int'(instruction) >> 1) % 16;
      if (flush) begin
         model_clear(); busy = 0; flushing = 1; store_pending = 0;
      end else if (stall) begin
         flushing = 0;
      end else if (flushing) begin
         flushing = 0; model_clear();
      end else if (busy > 0) begin
         busy--;
         if (busy == 0) e_flags[3] = store_pending;
      end else if (in_valid) begin
         e_valid = 1; e_illegal = 0;
         e_alu   = alu_tbl[opn];
         e_flags = flag_tbl[opn];
         if ((opn == 12 || opn == 13) && instruction[0]) e_flags[1] = 1;
         if (opn == 1 || opn == 2) begin
            busy          = MEM_LAT - 1;
            store_pending = (opn == 2);
            if (busy > 0) e_flags[3] = 0;
         end
`ifdef CTRL_ILLEGAL_TRAP_EN
         if (opn >= 14) begin
            e_illegal = 1; flushing = 1;
         end
`endif
      end else begin
         model_clear();
      end
   endtask

   // One clock: drive inputs, check ready, take the edge, check outputs.
   task automatic cyc(input logic iv, input logic [INSTR_W-1:0] ins,
                      input logic st, input logic fl);
      in_valid = iv; instruction = ins; stall = st; flush = fl;
      #1;
      check("in_ready", 32'(in_ready), 32'(model_ready()));
      @(posedge clk);
      model_step();
      #1;
      check("outputs", dut_word(), model_word());
   endtask

   // Asynchronous reset asserted away from the clock edge.
   task automatic do_reset();
      reset_n = 1'b0;
      #2;
      model_reset();
      check("reset_outputs", dut_word(), model_word());
      check("reset_ready", 32'(in_ready), 32'(0));
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      alu_tbl  = '{4'd7, 4'd7, 4'd7, 4'd5, 4'd6, 4'd1, 4'd2, 4'd0,
                   4'd7, 4'd10, 4'd8, 4'd9, 4'd3, 4'd4, 4'd0, 4'd0};
      flag_tbl = '{6'b000101, 6'b010100, 6'b001000, 6'b000100,
                   6'b000100, 6'b000100, 6'b000100, 6'b000100,
                   6'b100000, 6'b100000, 6'b100000, 6'b100000,
                   6'b000100, 6'b000100, 6'b000000, 6'b000000};
      in_valid = 0; instruction = '0; stall = 0; flush = 0; reset_n = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      do_reset();

      // add
      cyc(1, 9'b000000110, 0, 0);
      check("add_aluop", 32'(ALUOp), 32'(5));
      check("add_regwrite", 32'(regWriteFlag), 32'(1));
      cyc(0, '0, 0, 0);

      // store: two output cycles, write strobe on the second
      cyc(1, 9'b000000100, 0, 0);
      check("st_first_mw", 32'(memWriteFlag), 32'(0));
      cyc(0, '0, 0, 0);
      check("st_second_mw", 32'(memWriteFlag), 32'(1));
      check("st_regwrite", 32'(regWriteFlag), 32'(0));
      cyc(0, '0, 0, 0);

      // beq held by stall for three cycles
      cyc(1, 9'b000010010, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(1, 9'b000000110, 1, 0);
         check("beq_hold_alu", 32'(ALUOp), 32'(10));
         check("beq_hold_br", 32'(branchFlag), 32'(1));
      end
      cyc(0, '0, 0, 0);

      // load mem, then flush inside MEM_WAIT
      cyc(1, 9'b000000010, 0, 0);
      cyc(0, '0, 0, 1);
      check("flush_valid", 32'(out_valid), 32'(0));
      cyc(0, '0, 0, 0);
      cyc(0, '0, 0, 0);

      // opcode 15
      cyc(1, 9'b000011110, 0, 0);
`ifdef CTRL_ILLEGAL_TRAP_EN
      check("op15_illegal", 32'(illegal), 32'(1));
`else
      check("op15_illegal", 32'(illegal), 32'(0));
`endif
      cyc(0, '0, 0, 0);
      cyc(0, '0, 0, 0);

      // reset in the middle of a store
      cyc(1, 9'b000000100, 0, 0);
      do_reset();
      for (int i = 0; i < 3; i++) cyc(0, '0, 0, 0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) do_reset();
         else cyc(($urandom_range(0, 9) < 7), INSTR_W'($urandom),
                  ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 5));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
